// File: rtl/mips_cpu_harvard_dmem_bridge.sv
// Data-side bridge between the Harvard MIPS core and a variable-latency RAM.
// Posted single-entry write buffer, read stall/return, store forwarding, access timeout.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | no access in flight; accepts a write (posted) or a read (stall)
// S_WR_BUSY | buffered write on the bus, mem_write high
// S_RD_BUSY | read on the bus, mem_read high, CPU stalled
// S_RD_DONE | one-cycle return of the captured (or error) read data
module mips_cpu_harvard_dmem_bridge #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        clk_enable,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        bus_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WR_BUSY = 2'd1,
    S_RD_BUSY = 2'd2,
    S_RD_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_mem_address;
  logic [31:0]        r_mem_writedata;
  logic               r_mem_write;
  logic               r_mem_read;
  logic [31:0]        r_rdata;
  logic               r_bus_error;
  logic               w_clk_enable;
  logic               w_fwd;
  logic               w_timeout;
  logic               w_unused;

  // The write buffer is the bus address/data registers themselves while in S_WR_BUSY.
  assign w_fwd     = (r_state == S_WR_BUSY) && data_read && !data_write &&
                     (data_address[31:2] == r_mem_address[31:2]);
  assign w_timeout = mem_waitrequest && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_unused  = ^data_address[1:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_clk_enable = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (data_write) begin
          w_state_nxt = S_WR_BUSY;
        end else if (data_read) begin
          w_state_nxt  = S_RD_BUSY;
          w_clk_enable = 1'b0;
        end
      end
      S_WR_BUSY: begin
        if (!w_fwd && (data_read || data_write)) w_clk_enable = 1'b0;
        if (!mem_waitrequest || w_timeout) w_state_nxt = S_IDLE;
      end
      S_RD_BUSY: begin
        w_clk_enable = 1'b0;
        if (!mem_waitrequest || w_timeout) w_state_nxt = S_RD_DONE;
      end
      S_RD_DONE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt           <= '0;
      r_mem_address   <= '0;
      r_mem_writedata <= '0;
      r_mem_write     <= 1'b0;
      r_mem_read      <= 1'b0;
      r_rdata         <= '0;
      r_bus_error     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (data_write) begin
            r_mem_write     <= 1'b1;
            r_mem_address   <= {data_address[31:2], 2'b00};
            r_mem_writedata <= data_writedata;
            r_cnt           <= '0;
          end else if (data_read) begin
            r_mem_read    <= 1'b1;
            r_mem_address <= {data_address[31:2], 2'b00};
            r_cnt         <= '0;
          end
        end
        S_WR_BUSY: begin
          if (w_fwd) r_rdata <= r_mem_writedata;
          if (!mem_waitrequest) begin
            r_mem_write <= 1'b0;
          end else if (w_timeout) begin
            // Hung write: data is dropped, only the sticky error records it.
            r_mem_write <= 1'b0;
            r_bus_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RD_BUSY: begin
          if (!mem_waitrequest) begin
            r_mem_read <= 1'b0;
            r_rdata    <= mem_readdata;
          end else if (w_timeout) begin
            r_mem_read  <= 1'b0;
            r_rdata     <= ERR_DATA;
            r_bus_error <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Reset forces the CPU to run so it is never frozen on a dead request.
  assign clk_enable    = !reset || w_clk_enable;
  assign data_readdata = w_fwd ? r_mem_writedata : r_rdata;
  assign mem_address   = r_mem_address;
  assign mem_writedata = r_mem_writedata;
  assign mem_write     = r_mem_write;
  assign mem_read      = r_mem_read;
  assign bus_error     = r_bus_error;

endmodule
